axi4_stream_rr_pkt_arb: RTL and testbench

Round-robin, packet-granular arbiter that shares the frame buffer's single 64-bit AXI4-Stream path (upstream of the 64b→16b gearbox) between `CHANNELS_NUM` 64-bit sources. A grant is held from a packet's first beat through its `tlast` beat, so packets are never interleaved. The next grant goes to the next requesting channel after the last served one.

---
 rtl/axi4_stream_arb_pkg.sv | 41 ++++
 rtl/axi4_stream_if.sv | 34 +++
 rtl/axi4_stream_rr_pkt_arb_rr_grant_sel.sv | 32 +++
 rtl/axi4_stream_rr_pkt_arb.sv | 154 +++++++++++++++
 tb/tb_axi4_stream_rr_pkt_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_arb_pkg.sv
// ----------------------------------------------------------------------------
// axi4_stream_arb_pkg
// Types and helpers shared by the round-robin packet arbiter:
//   ARB_MAX_CHANNELS : largest supported channel count (16)
//   ARB_IDX_W        : width of a channel index at ARB_MAX_CHANNELS
//   arb_state_t      : arbiter FSM state {IDLE, LOCKED}
//   rr_next()        : next round-robin grant index after 'last'
// ----------------------------------------------------------------------------
package axi4_stream_arb_pkg;

  localparam int ARB_MAX_CHANNELS = 16;
  localparam int ARB_IDX_W        = $clog2(ARB_MAX_CHANNELS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Returns the first set bit of 'req' searching from last+1 upward, wrapping
  // at ARB_MAX_CHANNELS. Request bits at or above the real channel count are
  // always zero, so skipping over them is the same as wrapping modulo the
  // real channel count; this keeps non-power-of-two counts correct without a
  // divider. With no request set, 'last' is returned unchanged.
  function automatic logic [ARB_IDX_W-1:0] rr_next(
    input logic [ARB_MAX_CHANNELS-1:0] req,
    input logic [ARB_IDX_W-1:0]        last
  );
    logic [ARB_IDX_W-1:0] idx;
    logic                 hit;
    rr_next = last;
    hit     = 1'b0;
    for (int i = 1; i <= ARB_MAX_CHANNELS; i++) begin
      idx = last + ARB_IDX_W'(i);
      if (!hit && req[idx]) begin
        rr_next = idx;
        hit     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// ----------------------------------------------------------------------------
// axi4_stream_if
// Plain AXI4-Stream bundle.
//   master modport : drives tvalid + payload, receives tready
//   slave  modport : receives tvalid + payload, drives tready
// Payload: tdata[TDATA_WIDTH], tkeep/tstrb[TDATA_WIDTH/8], tlast,
//          tid[TID_WIDTH], tdest[TDEST_WIDTH], tuser[TUSER_WIDTH]
// ----------------------------------------------------------------------------
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 64,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_rr_pkt_arb_rr_grant_sel.sv
// ----------------------------------------------------------------------------
// rr_grant_sel
// Combinational round-robin selector.
//   req_i   [CHANNELS_NUM] : per-channel request (tvalid)
//   last_i  [IDX_W]        : index of the channel served last
//   found_o                : at least one request is present
//   next_o  [IDX_W]        : first requester after last_i, wrapping
// ----------------------------------------------------------------------------
module rr_grant_sel
  import axi4_stream_arb_pkg::*;
#(
  parameter  int CHANNELS_NUM = 4,
  localparam int IDX_W        = $clog2(CHANNELS_NUM)
) (
  input  logic [CHANNELS_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]        last_i,
  output logic                    found_o,
  output logic [IDX_W-1:0]        next_o
);

  logic [ARB_MAX_CHANNELS-1:0] req_ext;
  logic [ARB_IDX_W-1:0]        last_ext;
  logic [ARB_IDX_W-1:0]        next_ext;

  assign req_ext  = ARB_MAX_CHANNELS'(req_i);
  assign last_ext = ARB_IDX_W'(last_i);
  assign next_ext = rr_next(req_ext, last_ext);

  assign found_o = |req_i;
  assign next_o  = IDX_W'(next_ext);

endmodule

// File: rtl/axi4_stream_rr_pkt_arb.sv
// ----------------------------------------------------------------------------
// axi4_stream_rr_pkt_arb
// Packet-granular round-robin arbiter sharing one AXI4-Stream output between
// CHANNELS_NUM sources. A grant is taken in IDLE (one cycle) and held until
// the tlast handshake, so packets never interleave. The data path is purely
// combinational while LOCKED.
//
// Ports:
//   clk_i                 : clock
//   rst_i                 : asynchronous, active-high reset
//   pkt_i[CHANNELS_NUM]   : source channels (slave)
//   pkt_o                 : arbitrated stream (master)
//
// Build option:
//   RR_ARB_TID_STAMP_EN   : when defined, pkt_o.tid carries the granted
//                           channel index instead of the source tid.
// ----------------------------------------------------------------------------
module axi4_stream_rr_pkt_arb
  import axi4_stream_arb_pkg::*;
#(
  parameter  int CHANNELS_NUM = 4,
  parameter  int TDATA_WIDTH  = 64,
  parameter  int TID_WIDTH    = 1,
  parameter  int TDEST_WIDTH  = 1,
  parameter  int TUSER_WIDTH  = 1,
  localparam int IDX_W        = $clog2(CHANNELS_NUM),
  localparam int KEEP_W       = TDATA_WIDTH / 8
) (
  input logic           clk_i,
  input logic           rst_i,
  axi4_stream_if.slave  pkt_i [CHANNELS_NUM],
  axi4_stream_if.master pkt_o
);

  if (CHANNELS_NUM < 2 || CHANNELS_NUM > ARB_MAX_CHANNELS) begin : g_bad_channels
    $error("axi4_stream_rr_pkt_arb: CHANNELS_NUM must be 2..%0d", ARB_MAX_CHANNELS);
  end

  // Flattened view of the source channels so they can be indexed by grant.
  logic [CHANNELS_NUM-1:0] req_vec;
  logic [CHANNELS_NUM-1:0] last_vec;
  logic [CHANNELS_NUM-1:0] tready_vec;
  logic [TDATA_WIDTH-1:0]  tdata_arr [CHANNELS_NUM];
  logic [KEEP_W-1:0]       tkeep_arr [CHANNELS_NUM];
  logic [KEEP_W-1:0]       tstrb_arr [CHANNELS_NUM];
  logic [TDEST_WIDTH-1:0]  tdest_arr [CHANNELS_NUM];
  logic [TUSER_WIDTH-1:0]  tuser_arr [CHANNELS_NUM];
`ifndef RR_ARB_TID_STAMP_EN
  logic [TID_WIDTH-1:0]    tid_arr   [CHANNELS_NUM];
`endif

  for (genvar g = 0; g < CHANNELS_NUM; g++) begin : g_chan
    assign req_vec[g]     = pkt_i[g].tvalid;
    assign last_vec[g]    = pkt_i[g].tlast;
    assign tdata_arr[g]   = pkt_i[g].tdata;
    assign tkeep_arr[g]   = pkt_i[g].tkeep;
    assign tstrb_arr[g]   = pkt_i[g].tstrb;
    assign tdest_arr[g]   = pkt_i[g].tdest;
    assign tuser_arr[g]   = pkt_i[g].tuser;
`ifndef RR_ARB_TID_STAMP_EN
    assign tid_arr[g]     = pkt_i[g].tid;
`endif
    assign pkt_i[g].tready = tready_vec[g];
  end

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             out_tvalid;
  logic             xfer_last;

  rr_grant_sel #(
    .CHANNELS_NUM (CHANNELS_NUM)
  ) u_grant_sel (
    .req_i   (req_vec),
    .last_i  (last_grant),
    .found_o (sel_found),
    .next_o  (sel_idx)
  );

  // State register. last_grant resets to the top index so channel 0 is the
  // first winner after reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(CHANNELS_NUM - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign xfer_last = out_tvalid & pkt_o.tready & last_vec[grant];

  // Next-state logic.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (sel_found) begin
          grant_nxt = sel_idx;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // Only the tlast handshake releases the lock; other requests wait.
        if (xfer_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: handshake steering. Payload below is a plain mux of the
  // granted channel in every state; it is only meaningful while tvalid is 1.
  always_comb begin
    out_tvalid = 1'b0;
    tready_vec = '0;
    if (state == LOCKED) begin
      out_tvalid        = req_vec[grant];
      tready_vec[grant] = pkt_o.tready;
    end
  end

  assign pkt_o.tvalid = out_tvalid;
  assign pkt_o.tdata  = tdata_arr[grant];
  assign pkt_o.tkeep  = tkeep_arr[grant];
  assign pkt_o.tstrb  = tstrb_arr[grant];
  assign pkt_o.tlast  = last_vec[grant];
  assign pkt_o.tdest  = tdest_arr[grant];
  assign pkt_o.tuser  = tuser_arr[grant];

`ifdef RR_ARB_TID_STAMP_EN
  if (TID_WIDTH < IDX_W) begin : g_bad_tid_width
    $error("axi4_stream_rr_pkt_arb: TID_WIDTH too small to carry the channel index");
  end
  assign pkt_o.tid = TID_WIDTH'(grant);
`else
  assign pkt_o.tid = tid_arr[grant];
`endif

endmodule

// File: tb/tb_axi4_stream_rr_pkt_arb.sv
// ----------------------------------------------------------------------------
// tb_axi4_stream_rr_pkt_arb
// Self-checking bench for axi4_stream_rr_pkt_arb (4 channels, 64-bit data).
// Per-channel source models replay queued beats; expected output beats are
// pushed to a scoreboard queue in the order the arbiter must produce them and
// are checked by a monitor on every output handshake. Each scenario task also
// checks per-cycle tvalid/tready against a timing table.
// ----------------------------------------------------------------------------
module tb_axi4_stream_rr_pkt_arb;
  import axi4_stream_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int TIDW  = 2;
  localparam int TDW   = 1;
  localparam int TUW   = 1;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 64;
  localparam int CMPW  = DW + 1 + TIDW + TDW + TUW + 2 * KW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_last;
  logic [N-1:0]  s_ready;
  logic [DW-1:0] s_data [N];
  logic          o_ready;

  // Source models: per-channel beat memories with read/write pointers.
  logic [DW-1:0] mem_data [N][DEPTH];
  logic          mem_last [N][DEPTH];
  int            rd [N];
  int            wr [N];
  logic [N-1:0]  hs;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW), .TUSER_WIDTH(TUW)) src_if [N] ();
  axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW), .TUSER_WIDTH(TUW)) out_if ();

  for (genvar g = 0; g < N; g++) begin : g_src
    localparam logic [1:0] CH = 2'(g);
    assign src_if[g].tvalid = s_valid[g];
    assign src_if[g].tdata  = s_data[g];
    assign src_if[g].tlast  = s_last[g];
    assign src_if[g].tkeep  = '1;
    assign src_if[g].tstrb  = '1;
    assign src_if[g].tid    = ~CH;
    assign src_if[g].tdest  = CH[0];
    assign src_if[g].tuser  = CH[1];
    assign s_ready[g]       = src_if[g].tready;
  end
  assign out_if.tready = o_ready;

  axi4_stream_rr_pkt_arb #(
    .CHANNELS_NUM (N),
    .TDATA_WIDTH  (DW),
    .TID_WIDTH    (TIDW),
    .TDEST_WIDTH  (TDW),
    .TUSER_WIDTH  (TUW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pkt_i (src_if),
    .pkt_o (out_if)
  );

  function automatic logic [TIDW-1:0] exp_tid(input logic [1:0] ch);
`ifdef RR_ARB_TID_STAMP_EN
    return ch;
`else
    return ~ch;
`endif
  endfunction

  // Scoreboard monitor: every output handshake must match the queue head.
  always @(negedge clk) begin
    exp_t           e;
    logic [CMPW-1:0] got, want;
    if (out_if.tvalid === 1'b1 && o_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got beat tdata=%h, want no beat (queue empty)", out_if.tdata);
      end else begin
        e    = exp_q.pop_front();
        got  = {out_if.tdata, out_if.tlast, out_if.tid, out_if.tdest, out_if.tuser, out_if.tkeep, out_if.tstrb};
        want = {e.data, e.last, exp_tid(e.ch), e.ch[0], e.ch[1], {KW{1'b1}}, {KW{1'b1}}};
        if (got !== want) begin
          n_errors++;
          $display("FAIL sb_beat: got %h want %h (data,last,tid,dest,user,keep,strb)", got, want);
        end
      end
    end
  end

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (rd[k] < wr[k]) begin
        s_valid[k] = 1'b1;
        s_data[k]  = mem_data[k][rd[k]];
        s_last[k]  = mem_last[k][rd[k]];
      end else begin
        s_valid[k] = 1'b0;
        s_data[k]  = '0;
        s_last[k]  = 1'b0;
      end
    end
  endtask

  // One clock: advance sources that handshook, drive, settle to the negedge.
  task automatic step(input logic rdy);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (hs[k]) rd[k]++;
    o_ready = rdy;
    drive();
    @(negedge clk);
    for (int k = 0; k < N; k++) hs[k] = s_valid[k] & s_ready[k];
  endtask

  task automatic load_pkt(input int ch, input int nb, input logic [DW-1:0] base);
    for (int b = 0; b < nb; b++) begin
      mem_data[ch][wr[ch]] = base + DW'(b);
      mem_last[ch][wr[ch]] = (b == nb - 1);
      wr[ch]++;
    end
  endtask

  task automatic expect_pkt(input int ch, input int nb, input int npush, input logic [DW-1:0] base);
    for (int b = 0; b < npush; b++)
      exp_q.push_back('{data: base + DW'(b), last: (b == nb - 1), ch: 2'(ch)});
  endtask

  task automatic flush_sources();
    for (int k = 0; k < N; k++) begin
      rd[k] = wr[k];
      hs[k] = 1'b0;
    end
    drive();
  endtask

  task automatic hold_reset();
    flush_sources();
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({out_if.tvalid, s_ready} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_handshake: got tvalid/tready %b want 00000", {out_if.tvalid, s_ready});
    end
    n_checks++;
    if ({out_if.tdata, out_if.tid} !== {64'hA0, exp_tid(2'd0)}) begin
      n_errors++;
      $display("FAIL reset_mirror_ch0: got %h/%h want %h/%h", out_if.tdata, out_if.tid, 64'hA0, exp_tid(2'd0));
    end
    n_checks++;
    if ({dut.state, dut.grant, dut.last_grant} !== {IDLE, 2'd0, 2'd3}) begin
      n_errors++;
      $display("FAIL reset_regs: got state/grant/last %b want %b", {dut.state, dut.grant, dut.last_grant}, {IDLE, 2'd0, 2'd3});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_source();
    load_pkt(0, 4, 64'h1);
    expect_pkt(0, 4, 4, 64'h1);
    for (int c = 0; c < 6; c++) begin
      logic v;
      v = (c >= 1 && c <= 4);
      step(1'b1);
      n_checks++;
      if ({out_if.tvalid, s_ready} !== {v, 3'b000, v}) begin
        n_errors++;
        $display("FAIL single_timing c%0d: got %b want %b", c, {out_if.tvalid, s_ready}, {v, 3'b000, v});
      end
      if (v) begin
        n_checks++;
        if ({out_if.tdata, out_if.tlast} !== {64'(c), (c == 4)}) begin
          n_errors++;
          $display("FAIL single_beat c%0d: got %h/%b want %h/%b", c, out_if.tdata, out_if.tlast, 64'(c), (c == 4));
        end
      end
    end
    n_checks++;
    if (dut.state !== IDLE) begin
      n_errors++;
      $display("FAIL single_idle_after: got state %b want %b", dut.state, IDLE);
    end
  endtask

  task automatic test_all_contend();
    int order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    hold_reset();
    load_pkt(0, 2, 64'h000);
    load_pkt(0, 2, 64'h010);
    load_pkt(1, 2, 64'h100);
    load_pkt(2, 2, 64'h200);
    load_pkt(3, 2, 64'h300);
    expect_pkt(0, 2, 2, 64'h000);
    expect_pkt(1, 2, 2, 64'h100);
    expect_pkt(2, 2, 2, 64'h200);
    expect_pkt(3, 2, 2, 64'h300);
    expect_pkt(0, 2, 2, 64'h010);
    for (int c = 0; c < 16; c++) begin
      logic [4:0] want;
      want = 5'b0;
      if (c > 0 && ((c - 1) % 3) != 2) want = {1'b1, 4'(1 << order[(c - 1) / 3])};
      step(1'b1);
      n_checks++;
      if ({out_if.tvalid, s_ready} !== want) begin
        n_errors++;
        $display("FAIL all_contend c%0d: got %b want %b", c, {out_if.tvalid, s_ready}, want);
      end
    end
  endtask

  task automatic test_non_preempt();
    logic [4:0] tbl [11] = '{5'b0_0000, 5'b1_0100, 5'b1_0100, 5'b1_0100, 5'b1_0100, 5'b0_0000,
                             5'b1_1000, 5'b1_1000, 5'b0_0000, 5'b1_0001, 5'b0_0000};
    load_pkt(2, 4, 64'h2A0);
    expect_pkt(2, 4, 4, 64'h2A0);
    expect_pkt(3, 2, 2, 64'h3A0);
    expect_pkt(0, 1, 1, 64'h0A0);
    for (int c = 0; c < 11; c++) begin
      if (c == 2) load_pkt(0, 1, 64'h0A0);
      if (c == 3) load_pkt(3, 2, 64'h3A0);
      step(1'b1);
      n_checks++;
      if ({out_if.tvalid, s_ready} !== tbl[c]) begin
        n_errors++;
        $display("FAIL non_preempt c%0d: got %b want %b", c, {out_if.tvalid, s_ready}, tbl[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    load_pkt(1, 4, 64'h1B0);
    expect_pkt(1, 4, 4, 64'h1B0);
    expect_pkt(3, 1, 1, 64'h3B0);
    for (int c = 0; c < 11; c++) begin
      logic       rdy;
      logic [4:0] want;
      rdy  = (c >= 1 && c <= 7) ? c[0] : 1'b1;
      want = 5'b0;
      if (c >= 1 && c <= 7) want = {1'b1, 2'b00, rdy, 1'b0};
      if (c == 9)           want = 5'b1_1000;
      if (c == 2) load_pkt(3, 1, 64'h3B0);
      step(rdy);
      n_checks++;
      if ({out_if.tvalid, s_ready} !== want) begin
        n_errors++;
        $display("FAIL backpressure c%0d: got %b want %b", c, {out_if.tvalid, s_ready}, want);
      end
      if (c >= 1 && c <= 7) begin
        n_checks++;
        if (out_if.tdata !== 64'h1B0 + 64'(c / 2)) begin
          n_errors++;
          $display("FAIL backpressure_data c%0d: got %h want %h", c, out_if.tdata, 64'h1B0 + 64'(c / 2));
        end
      end
    end
  endtask

  task automatic test_single_beat();
    logic [4:0] tbl [7] = '{5'b0_0000, 5'b1_0100, 5'b0_0000, 5'b1_1000, 5'b0_0000, 5'b1_0001, 5'b0_0000};
    load_pkt(2, 1, 64'h2C0);
    expect_pkt(2, 1, 1, 64'h2C0);
    expect_pkt(3, 1, 1, 64'h3C0);
    expect_pkt(0, 1, 1, 64'h0C0);
    for (int c = 0; c < 7; c++) begin
      if (c == 2) begin
        load_pkt(3, 1, 64'h3C0);
        load_pkt(0, 1, 64'h0C0);
      end
      step(1'b1);
      n_checks++;
      if ({out_if.tvalid, s_ready} !== tbl[c]) begin
        n_errors++;
        $display("FAIL single_beat c%0d: got %b want %b", c, {out_if.tvalid, s_ready}, tbl[c]);
      end
      if (c == 3 || c == 5) begin
        n_checks++;
        if (out_if.tid !== exp_tid((c == 3) ? 2'd3 : 2'd0)) begin
          n_errors++;
          $display("FAIL single_beat_tid c%0d: got %0d want %0d", c, out_if.tid, exp_tid((c == 3) ? 2'd3 : 2'd0));
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [4:0] tbl [5] = '{5'b0_0000, 5'b1_0001, 5'b0_0000, 5'b1_0010, 5'b0_0000};
    load_pkt(1, 5, 64'h1D0);
    expect_pkt(1, 5, 2, 64'h1D0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    n_checks++;
    if ({out_if.tvalid, s_ready} !== 5'b1_0010) begin
      n_errors++;
      $display("FAIL rst_mid_pre: got %b want %b", {out_if.tvalid, s_ready}, 5'b1_0010);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_if.tvalid, s_ready, dut.state} !== {5'b0, IDLE}) begin
      n_errors++;
      $display("FAIL rst_mid_async: got %b want %b", {out_if.tvalid, s_ready, dut.state}, {5'b0, IDLE});
    end
    hold_reset();
    load_pkt(1, 1, 64'h1E0);
    load_pkt(0, 1, 64'h0E0);
    expect_pkt(0, 1, 1, 64'h0E0);
    expect_pkt(1, 1, 1, 64'h1E0);
    for (int c = 0; c < 5; c++) begin
      step(1'b1);
      n_checks++;
      if ({out_if.tvalid, s_ready} !== tbl[c]) begin
        n_errors++;
        $display("FAIL rst_mid_after c%0d: got %b want %b", c, {out_if.tvalid, s_ready}, tbl[c]);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    o_ready = 1'b0;
    hs      = '0;
    s_valid = '0;
    s_last  = '0;
    for (int k = 0; k < N; k++) begin
      rd[k]     = 0;
      wr[k]     = 0;
      s_data[k] = 64'hA0 + 64'(k);
    end

    test_reset();
    test_single_source();
    test_all_contend();
    test_non_preempt();
    test_backpressure();
    test_single_beat();
    test_reset_mid_packet();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d beats outstanding want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
